regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback requesters
//  (req0 = ALU writeback, req1 = load writeback), one accepted write per cycle.
//  Round-robin arbitration with a valid/ready handshake into one registered output
//  stage that drives the write port and its 32-bit one-hot write-enable vector.
//  Writes to X31 (zero register) are accepted and silently discarded.
//  Sits between the writeback stage and the register file write decode.
// PARAMETERS
//  DATA_W  64  width of write data
//  ADDR_W  5   register address width (32 registers; X31 = zero register)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   2       bit i: requester i has a write pending
//  req_ready  out  2       bit i: requester i's write accepted this cycle
//  req0_addr  in   ADDR_W  requester 0 destination register
//  req0_data  in   DATA_W  requester 0 write data
//  req1_addr  in   ADDR_W  requester 1 destination register
//  req1_data  in   DATA_W  requester 1 write data
//  wr_stall   in   1       register file cannot take a write this cycle
//  wr_en      out  1       register file write strobe
//  wr_addr    out  ADDR_W  register file write address
//  wr_data    out  DATA_W  register file write data
//  wr_dec     out  32      one-hot of wr_addr when wr_en=1, else all zero
//  busy       out  1       output stage holds a write (out_valid)
// BEHAVIOUR
//  - State: out_valid, out_addr, out_data, last_grant (1 bit, last requester granted).
//  - Reset (async, immediate): out_valid=0, out_addr=0, out_data=0, last_grant=1
//    (req0 wins first contention). Reset mid-transfer drops the held write; no write.
//  - load_ok = !out_valid | !wr_stall (combinational).
//  - Grant (combinational): one valid -> that requester; both valid -> !last_grant;
//    none -> no grant. req_ready = one-hot grant & {2{load_ok}}; never both bits set.
//  - Handshake: transfer when req_valid[i] & req_ready[i]. Requester holds valid and
//    stable addr/data until ready. Ready never depends on the requester's own payload.
//  - On transfer: out_addr/out_data <= granted payload, out_valid <= 1,
//    last_grant <= granted index. last_grant changes only on a transfer.
//  - No transfer and !wr_stall: out_valid <= 0. wr_stall=1 with out_valid=1: stage
//    holds addr/data unchanged, req_ready=0.
//  - wr_en = out_valid & !wr_stall & (out_addr != 31). wr_addr=out_addr, wr_data=out_data.
//  - Latency: accepted in cycle N -> wr_en in cycle N+1 (no stall); each stalled cycle
//    adds one. Throughput: one write per cycle while wr_stall=0.
//  - Addr 31: handshake completes normally and occupies the stage one cycle; wr_en=0,
//    wr_dec=0.
//  - Same address from both requesters in back-to-back cycles: both written in grant
//    order; the later write wins. No merging or reordering.
//  - wr_dec: exactly one bit set (bit wr_addr) when wr_en=1; bit 31 never set.
// TESTING
//  1. Reset asserted mid-write (out_valid=1): wr_en, busy, req_ready drop to 0
//     immediately; after release req_valid=2'b11 -> req_ready=2'b01.
//  2. Single requester: req_valid=2'b10, req1_addr=5, req1_data=0xAB -> req_ready=2'b10;
//     next cycle wr_en=1, wr_addr=5, wr_data=0xAB, wr_dec=32'h0000_0020.
//  3. Contention: req_valid=2'b11 held 4 cycles, new payloads each cycle -> grants
//     alternate 0,1,0,1; wr_en high 4 consecutive cycles starting one cycle later.
//  4. Stall: write to X7 in stage, wr_stall=1 for 3 cycles -> wr_en=0, req_ready=0,
//     busy=1, payload stable; wr_stall=0 -> wr_en=1, wr_addr=7, new grant same cycle.
//  5. Zero register: req0_addr=31 accepted -> req_ready[0]=1, busy=1 next cycle,
//     wr_en=0, wr_dec=0; last_grant=0 so next contention grants req1.
//  6. Exhaustive decode: addresses 0..30 via req0 -> wr_dec == 1<<addr each; popcount 1.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester / register-file write port bundle
//
// Purpose: groups the two writeback request channels and the register file
// write port that regfile_wb_arbiter sits between.
//
// Signals:
//   req_valid[1:0]  requester i has a write pending
//   req_ready[1:0]  requester i's write accepted this cycle
//   req0_addr/data  requester 0 (ALU writeback) destination and data
//   req1_addr/data  requester 1 (load writeback) destination and data
//   wr_stall        register file cannot take a write this cycle
//   wr_en           register file write strobe
//   wr_addr/data    register file write address and data
//   wr_dec[31:0]    one-hot of wr_addr when wr_en=1, else zero
//   busy            output stage holds a write
//
// Modports: master = writeback stage + register file side, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       wr_dec;
  logic              busy;

  modport master (
    output req_valid, req0_addr, req0_data, req1_addr, req1_data, wr_stall,
    input  req_ready, wr_en, wr_addr, wr_data, wr_dec, busy
  );

  modport slave (
    input  req_valid, req0_addr, req0_data, req1_addr, req1_data, wr_stall,
    output req_ready, wr_en, wr_addr, wr_data, wr_dec, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the register file write port
//
// Purpose: shares the single register file write port between the ALU
// writeback (requester 0) and the load writeback (requester 1). One write is
// accepted per cycle into a registered output stage which drives the write
// port and its one-hot write-enable vector. Writes to X31 (zero register) are
// accepted and occupy the stage but never strobe the register file.
//
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of regfile_wb_arbiter_if (request channels + write port)
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              last_grant_q, last_grant_d;

  logic              load_ok;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              xfer;
  logic              xfer_idx;
  logic              wr_en;
  logic [31:0]       wr_dec;

  // The stage can take a new write when empty or when its current write
  // drains this cycle.
  assign load_ok = !out_valid_q || !bus.wr_stall;

  // Grant depends only on valids and history, never on payloads.
  always_comb begin
    grant = 2'b00;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // No handshake may complete while reset is held, so ready is masked too.
  assign ready    = reset ? 2'b00 : (grant & {2{load_ok}});
  assign xfer     = |ready;
  assign xfer_idx = ready[1];

  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_addr_d   = xfer_idx ? bus.req1_addr : bus.req0_addr;
      out_data_d   = xfer_idx ? bus.req1_data : bus.req0_data;
      last_grant_d = xfer_idx;
    end else if (!bus.wr_stall) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Zero-register writes drain through the stage without a strobe.
  assign wr_en = out_valid_q && !bus.wr_stall && (out_addr_q != ZERO_REG);

  always_comb begin
    wr_dec = 32'h0;
    if (wr_en) wr_dec = 32'h1 << out_addr_q;
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = out_addr_q;
  assign bus.wr_data   = out_data_q;
  assign bus.wr_dec    = wr_dec;
  assign bus.busy      = out_valid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus variables
  logic [1:0]  rv = 2'b00;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [63:0] d0 = '0, d1 = '0;
  logic        st = 1'b0;

  // reference model state
  logic        m_ov = 1'b0;
  logic        m_lg = 1'b1;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  logic [1:0]  last_ready = 2'b00;
  wr_t         sb[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_ov = 1'b0;
    m_lg = 1'b1;
    m_addr = '0;
    m_data = '0;
    sb.delete();
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model for the posedge.
  task automatic step(input string tag);
    logic        ew;
    logic [1:0]  g;
    logic [1:0]  er;
    logic [31:0] exp_dec;
    wr_t         e;
    @(negedge clk);
    bus.req_valid = rv;
    bus.req0_addr = a0;
    bus.req0_data = d0;
    bus.req1_addr = a1;
    bus.req1_data = d1;
    bus.wr_stall  = st;
    #1;
    ew = m_ov && !st && (m_addr != 5'd31);
    vectors++;
    if (bus.wr_en !== ew) begin
      miscompares++;
      $display("FAIL %s wr_en got %b exp %b", tag, bus.wr_en, ew);
    end
    vectors++;
    if (bus.busy !== m_ov) begin
      miscompares++;
      $display("FAIL %s busy got %b exp %b", tag, bus.busy, m_ov);
    end
    if (bus.wr_en === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL %s unexpected write addr %0d data %h exp none", tag, bus.wr_addr, bus.wr_data);
      end else begin
        e = sb.pop_front();
        exp_dec = 32'h1 << e.a;
        if (bus.wr_addr !== e.a || bus.wr_data !== e.d || bus.wr_dec !== exp_dec
            || $countones(bus.wr_dec) != 1) begin
          miscompares++;
          $display("FAIL %s write got addr %0d data %h dec %h exp addr %0d data %h dec %h",
                   tag, bus.wr_addr, bus.wr_data, bus.wr_dec, e.a, e.d, exp_dec);
        end
      end
    end else begin
      vectors++;
      if (bus.wr_dec !== 32'h0) begin
        miscompares++;
        $display("FAIL %s wr_dec idle got %h exp 0", tag, bus.wr_dec);
      end
    end
    case (rv)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = m_lg ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    er = (!m_ov || !st) ? g : 2'b00;
    vectors++;
    if (bus.req_ready !== er) begin
      miscompares++;
      $display("FAIL %s req_ready got %b exp %b", tag, bus.req_ready, er);
    end
    last_ready = er;
    if (|er) begin
      m_ov   = 1'b1;
      m_addr = er[1] ? a1 : a0;
      m_data = er[1] ? d1 : d0;
      m_lg   = er[1];
      if (m_addr != 5'd31) sb.push_back('{a: m_addr, d: m_data});
    end else if (!st) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rv = 2'b00;
    bus.req_valid = 2'b00;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    bus.req0_addr = '0;
    bus.req0_data = '0;
    bus.req1_addr = '0;
    bus.req1_data = '0;
    bus.wr_stall  = 1'b0;
    #2;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 2'b00 || bus.wr_dec !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state got wr_en %b busy %b ready %b dec %h exp 0 0 00 0",
               bus.wr_en, bus.busy, bus.req_ready, bus.wr_dec);
    end
    #5;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_first_grant got %b exp 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    model_reset();
  endtask

  task automatic test_reset_mid();
    rv = 2'b01; a0 = 5'd4; d0 = 64'h1234; st = 1'b0;
    step("mid_load");
    @(posedge clk);
    #2;
    bus.req_valid = 2'b11;
    #1;
    vectors++;
    if (bus.busy !== 1'b1 || bus.wr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre busy %b wr_en %b exp 1 1", bus.busy, bus.wr_en);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset got wr_en %b busy %b ready %b exp 0 0 00",
               bus.wr_en, bus.busy, bus.req_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_release_grant got %b exp 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    rv = 2'b00;
  endtask

  task automatic test_single();
    rv = 2'b10; a1 = 5'd5; d1 = 64'hAB; st = 1'b0;
    step("single_req");
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready got %b exp 10", bus.req_ready);
    end
    rv = 2'b00;
    step("single_wr");
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 64'hAB || bus.wr_dec !== 32'h0000_0020) begin
      miscompares++;
      $display("FAIL single_out got en %b addr %0d data %h dec %h exp 1 5 ab 00000020",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_dec);
    end
    step("single_drain");
  endtask

  task automatic test_contention();
    logic [1:0] exp_r;
    do_reset();
    st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv = 2'b11;
      a0 = 5'(i + 8);  d0 = {$urandom, $urandom};
      a1 = 5'(i + 16); d1 = {$urandom, $urandom};
      step("contend");
      exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if (last_ready !== exp_r || bus.req_ready !== exp_r) begin
        miscompares++;
        $display("FAIL contend_order cycle %0d got %b exp %b", i, bus.req_ready, exp_r);
      end
    end
    rv = 2'b00;
    step("contend_drain");
    step("contend_idle");
  endtask

  task automatic test_stall();
    rv = 2'b01; a0 = 5'd7; d0 = 64'h7777_0000_7777; st = 1'b0;
    step("stall_load");
    rv = 2'b11; a0 = 5'd9; d0 = 64'h99; a1 = 5'd10; d1 = 64'hAA; st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall_hold");
      vectors++;
      if (bus.wr_addr !== 5'd7 || bus.wr_data !== 64'h7777_0000_7777) begin
        miscompares++;
        $display("FAIL stall_payload got addr %0d data %h exp 7 777700007777", bus.wr_addr, bus.wr_data);
      end
    end
    st = 1'b0;
    step("stall_release");
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.req_ready === 2'b00) begin
      miscompares++;
      $display("FAIL stall_release got en %b addr %0d ready %b exp 1 7 nonzero",
               bus.wr_en, bus.wr_addr, bus.req_ready);
    end
    rv = 2'b00;
    step("stall_drain");
    step("stall_idle");
  endtask

  task automatic test_zero_reg();
    rv = 2'b01; a0 = 5'd31; d0 = 64'hDEAD; st = 1'b0;
    step("zero_load");
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL zero_ready got %b exp 01", bus.req_ready);
    end
    rv = 2'b00;
    step("zero_stage");
    vectors++;
    if (bus.busy !== 1'b1 || bus.wr_en !== 1'b0 || bus.wr_dec !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_stage got busy %b en %b dec %h exp 1 0 0", bus.busy, bus.wr_en, bus.wr_dec);
    end
    rv = 2'b11; a0 = 5'd1; d0 = 64'h11; a1 = 5'd2; d1 = 64'h22;
    step("zero_next");
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_next_grant got %b exp 10", bus.req_ready);
    end
    rv = 2'b00;
    step("zero_drain");
    step("zero_idle");
  endtask

  task automatic test_decode();
    st = 1'b0;
    for (int a = 0; a < 31; a++) begin
      rv = 2'b01; a0 = 5'(a); d0 = {$urandom, $urandom};
      step("decode");
    end
    rv = 2'b00;
    step("decode_drain");
    step("decode_idle");
  endtask

  task automatic test_back_to_back();
    st = 1'b0;
    rv = 2'b01; a0 = 5'd3; d0 = 64'h0000_0000_0000_0A0A;
    step("b2b_first");
    rv = 2'b10; a1 = 5'd3; d1 = 64'h0000_0000_0000_0B0B;
    step("b2b_second");
    rv = 2'b00;
    step("b2b_drain");
    step("b2b_idle");
  endtask

  task automatic test_random();
    logic [1:0] pv = 2'b00;
    for (int c = 0; c < 400; c++) begin
      if (!pv[0] || last_ready[0]) begin
        pv[0] = $urandom_range(0, 1) == 1;
        a0 = 5'($urandom_range(0, 31)); d0 = {$urandom, $urandom};
      end
      if (!pv[1] || last_ready[1]) begin
        pv[1] = $urandom_range(0, 1) == 1;
        a1 = 5'($urandom_range(0, 31)); d1 = {$urandom, $urandom};
      end
      rv = pv;
      st = $urandom_range(0, 3) == 0;
      step("random");
    end
    rv = 2'b00; st = 1'b0;
    step("random_drain");
    step("random_idle");
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got %0d pending exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_contention();
    test_stall();
    test_zero_reg();
    test_decode();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
